// File: rtl/trace_buffer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trace_buffer_ctrl_pkg
// Shared definitions for the double-buffered wall-trace store: entry layout,
// default frame geometry (also used by the ray tracer and the row renderer),
// the fill-state encoding and an entry packing helper.
// -----------------------------------------------------------------------------
package trace_buffer_ctrl_pkg;

    // Frame geometry defaults
    localparam int NUM_ROWS_DEF  = 480;
    localparam int ADDR_W_DEF    = 9;
    localparam int MISS_W_DEF    = 8;

    // Entry layout {wall, side, size, texu}
    localparam int TRACE_ENTRY_W = 20;
    localparam int WALL_W        = 2;
    localparam int SIDE_W        = 1;
    localparam int SIZE_W        = 11;
    localparam int TEXU_W        = 6;
    localparam int TEXU_LSB      = 0;
    localparam int SIZE_LSB      = TEXU_LSB + TEXU_W;
    localparam int SIDE_LSB      = SIZE_LSB + SIZE_W;
    localparam int WALL_LSB      = SIDE_LSB + SIDE_W;

    typedef logic [TRACE_ENTRY_W-1:0] trace_entry_t;

    // Back-bank fill state: IDLE only exists for the cycle after reset so
    // that the startup trace_start pulse comes out of the normal FSM path.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_FILL = 2'd1,
        FS_FULL = 2'd2
    } fill_state_t;

    function automatic trace_entry_t pack_entry(
        input logic [WALL_W-1:0] wall,
        input logic              side,
        input logic [SIZE_W-1:0] size,
        input logic [TEXU_W-1:0] texu
    );
        return {wall, side, size, texu};
    endfunction

endpackage

// File: rtl/trace_buffer_ctrl_if.sv
// -----------------------------------------------------------------------------
// trace_buffer_ctrl_if
// Bundles the tracer write handshake, frame control and the renderer read
// port of trace_buffer_ctrl.
//   slave  : the buffer controller (accepts writes, serves reads)
//   master : the environment (tracer, display timing and renderer)
// -----------------------------------------------------------------------------
interface trace_buffer_ctrl_if
    import trace_buffer_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int MISS_W = MISS_W_DEF
) ();

    // Tracer write side
    logic              wr_valid;
    logic              wr_ready;
    logic [WALL_W-1:0] wr_wall;
    logic              wr_side;
    logic [SIZE_W-1:0] wr_size;
    logic [TEXU_W-1:0] wr_texu;
    logic              trace_start;

    // Frame timing
    logic              frame_end;

    // Renderer read side
    logic              rd_en;
    logic [ADDR_W-1:0] rd_row;
    logic [WALL_W-1:0] row_wall;
    logic              row_side;
    logic [SIZE_W-1:0] row_size;
    logic [TEXU_W-1:0] row_texu;
    logic              front_valid;
    logic [MISS_W-1:0] missed_swaps;

    modport slave (
        input  wr_valid, wr_wall, wr_side, wr_size, wr_texu, frame_end,
        input  rd_en, rd_row,
        output wr_ready, trace_start, row_wall, row_side, row_size, row_texu,
        output front_valid, missed_swaps
    );

    modport master (
        output wr_valid, wr_wall, wr_side, wr_size, wr_texu, frame_end,
        output rd_en, rd_row,
        input  wr_ready, trace_start, row_wall, row_side, row_size, row_texu,
        input  front_valid, missed_swaps
    );

endinterface

// File: rtl/trace_buffer_ctrl_trace_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
// Two-bank trace entry store, addressed as {bank, row}. One write port and one
// synchronous read port whose output register doubles as the row_* outputs.
//   clk, reset : clock, async active-high reset (read register only)
//   we/waddr/wdata       : write port
//   re/rclr/raddr/rdata  : read port; rclr loads zero instead of RAM data,
//                          rdata holds when re is low
// -----------------------------------------------------------------------------
module trace_ram
    import trace_buffer_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ENTRY_W = TRACE_ENTRY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [ADDR_W:0]    waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               re,
    input  logic               rclr,
    input  logic [ADDR_W:0]    raddr,
    output logic [ENTRY_W-1:0] rdata
);

    // Full power-of-two depth so {bank, row} can be used directly as address.
    logic [ENTRY_W-1:0] mem_r [0:(2**(ADDR_W+1))-1];
    logic [ENTRY_W-1:0] rdata_r;

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register: loads on re, zero when the entry must render as no hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= {ENTRY_W{1'b0}};
        end else if (re) begin
            if (rclr) begin
                rdata_r <= {ENTRY_W{1'b0}};
            end else begin
                rdata_r <= mem_r[raddr];
            end
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/trace_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// trace_buffer_ctrl
// Double-buffered per-row wall-trace store between the ray tracer and the row
// renderer. The tracer fills the back bank through a valid/ready handshake;
// the renderer reads the front bank. Banks swap on frame_end only when the
// back bank is complete, otherwise the miss is counted and filling continues.
//   clk, reset : clock, async active-high reset
//   bus        : trace_buffer_ctrl_if.slave (write handshake, trace_start,
//                frame_end, read port, front_valid, missed_swaps)
// -----------------------------------------------------------------------------
module trace_buffer_ctrl
    import trace_buffer_ctrl_pkg::*;
#(
    parameter int NUM_ROWS = NUM_ROWS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MISS_W   = MISS_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    trace_buffer_ctrl_if.slave   bus
);

    fill_state_t         state_r;
    fill_state_t         state_next_s;
    logic                bank_sel_r;
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic                front_valid_r;
    logic [MISS_W-1:0]   missed_r;
    logic                wr_ready_r;
    logic                trace_start_r;

    logic                fire_s;
    logic                last_s;
    logic                done_s;
    logic                swap_s;
    logic                miss_s;
    logic                rd_clr_s;
    trace_entry_t        wdata_s;
    trace_entry_t        rdata_s;

    assign fire_s = bus.wr_valid && wr_ready_r;
    assign last_s = fire_s && (wr_ptr_r == ADDR_W'(NUM_ROWS - 1));
    // A final write landing in the frame_end cycle still counts as complete.
    assign done_s = (state_r == FS_FULL) || last_s;
    assign swap_s = bus.frame_end && done_s;
    assign miss_s = bus.frame_end && !done_s;

    // Next fill state: a swap always reopens the back bank for filling.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FS_IDLE: begin
                state_next_s = FS_FILL;
            end
            FS_FILL: begin
                if (last_s && !swap_s) begin
                    state_next_s = FS_FULL;
                end else begin
                    state_next_s = FS_FILL;
                end
            end
            FS_FULL: begin
                if (swap_s) begin
                    state_next_s = FS_FILL;
                end else begin
                    state_next_s = FS_FULL;
                end
            end
            default: begin
                state_next_s = FS_IDLE;
            end
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= FS_IDLE;
            wr_ready_r    <= 1'b0;
            trace_start_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            wr_ready_r    <= (state_next_s == FS_FILL);
            trace_start_r <= (state_r == FS_IDLE) || swap_s;
        end
    end

    // Bank select, write pointer and front-valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_sel_r    <= 1'b0;
            wr_ptr_r      <= {ADDR_W{1'b0}};
            front_valid_r <= 1'b0;
        end else if (swap_s) begin
            bank_sel_r    <= ~bank_sel_r;
            wr_ptr_r      <= {ADDR_W{1'b0}};
            front_valid_r <= 1'b1;
        end else if (fire_s) begin
            if (last_s) begin
                wr_ptr_r <= {ADDR_W{1'b0}};
            end else begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Saturating missed-swap counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            missed_r <= {MISS_W{1'b0}};
        end else if (miss_s && (missed_r != {MISS_W{1'b1}})) begin
            missed_r <= missed_r + MISS_W'(1);
        end else begin
            missed_r <= missed_r;
        end
    end

    assign wdata_s  = pack_entry(bus.wr_wall, bus.wr_side, bus.wr_size, bus.wr_texu);
    // Out-of-range rows and an empty front bank both read back as no hit.
    assign rd_clr_s = !front_valid_r ||
                      ({1'b0, bus.rd_row} >= (ADDR_W+1)'(NUM_ROWS));

    // Read uses the current (pre-swap) bank_sel; write targets the other bank.
    trace_ram #(
        .ADDR_W  (ADDR_W),
        .ENTRY_W (TRACE_ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (fire_s),
        .waddr ({~bank_sel_r, wr_ptr_r}),
        .wdata (wdata_s),
        .re    (bus.rd_en),
        .rclr  (rd_clr_s),
        .raddr ({bank_sel_r, bus.rd_row}),
        .rdata (rdata_s)
    );

    assign bus.wr_ready     = wr_ready_r;
    assign bus.trace_start  = trace_start_r;
    assign bus.front_valid  = front_valid_r;
    assign bus.missed_swaps = missed_r;
    assign bus.row_wall     = rdata_s[WALL_LSB +: WALL_W];
    assign bus.row_side     = rdata_s[SIDE_LSB];
    assign bus.row_size     = rdata_s[SIZE_LSB +: SIZE_W];
    assign bus.row_texu     = rdata_s[TEXU_LSB +: TEXU_W];

endmodule

// File: tb/tb_trace_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trace_buffer_ctrl
// Directed bench for trace_buffer_ctrl. Entry fields for row i of a frame with
// base b are derived from v=b+i: size=v, texu=v[5:0], wall=v[1:0], side=v[0].
// -----------------------------------------------------------------------------
module tb_trace_buffer_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    trace_buffer_ctrl_if #(.ADDR_W(9), .MISS_W(8)) bus ();

    trace_buffer_ctrl #(
        .NUM_ROWS (480),
        .ADDR_W   (9),
        .MISS_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input int v);
        bus.wr_wall = v[1:0];
        bus.wr_side = v[0];
        bus.wr_size = v[10:0];
        bus.wr_texu = v[5:0];
    endtask

    task automatic write_rows(input int first, input int last, input int base);
        for (int i = first; i <= last; i++) begin
            set_entry(base + i);
            bus.wr_valid = 1'b1;
            step();
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_row(input int row);
        bus.rd_en  = 1'b1;
        bus.rd_row = row[8:0];
        step();
        bus.rd_en  = 1'b0;
    endtask

    task automatic pulse_frame_end();
        bus.frame_end = 1'b1;
        step();
        bus.frame_end = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.wr_valid  = 1'b0;
        bus.wr_wall   = 2'd0;
        bus.wr_side   = 1'b0;
        bus.wr_size   = 11'd0;
        bus.wr_texu   = 6'd0;
        bus.frame_end = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_row    = 9'd0;

        // Reset state
        repeat (3) step();
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_trace_start", bus.trace_start, 0);
        chk("rst_front_valid", bus.front_valid, 0);
        chk("rst_missed", bus.missed_swaps, 0);
        chk("rst_row_size", bus.row_size, 0);

        // Startup pulse
        reset = 1'b0;
        step();
        chk("start_pulse", bus.trace_start, 1);
        chk("start_wr_ready", bus.wr_ready, 1);
        step();
        chk("start_pulse_end", bus.trace_start, 0);

        // Read with no front frame
        read_row(5);
        chk("idle_row_size", bus.row_size, 0);
        chk("idle_front_valid", bus.front_valid, 0);

        // Full fill of frame 1 (base 0)
        write_rows(0, 479, 0);
        chk("f1_wr_ready_drop", bus.wr_ready, 0);
        // Offered entry while not ready must be ignored
        set_entry(2047);
        bus.wr_valid = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        chk("f1_still_not_ready", bus.wr_ready, 0);
        pulse_frame_end();
        chk("f1_front_valid", bus.front_valid, 1);
        chk("f1_trace_start", bus.trace_start, 1);
        chk("f1_wr_ready", bus.wr_ready, 1);
        chk("f1_missed", bus.missed_swaps, 0);
        step();
        chk("f1_trace_start_end", bus.trace_start, 0);

        read_row(100);
        chk("f1_r100_size", bus.row_size, 100);
        chk("f1_r100_texu", bus.row_texu, 36);
        chk("f1_r100_wall", bus.row_wall, 0);
        read_row(479);
        chk("f1_r479_size", bus.row_size, 479);
        chk("f1_r479_texu", bus.row_texu, 31);
        chk("f1_r479_wall", bus.row_wall, 3);
        chk("f1_r479_side", bus.row_side, 1);
        step();
        chk("f1_hold", bus.row_size, 479);
        read_row(0);
        chk("f1_r0_ignored_write", bus.row_size, 0);
        read_row(300);
        read_row(500);
        chk("f1_oob_size", bus.row_size, 0);

        // Incomplete frame 2 (base 1000)
        write_rows(0, 199, 1000);
        pulse_frame_end();
        chk("f2_missed", bus.missed_swaps, 1);
        chk("f2_no_start", bus.trace_start, 0);
        chk("f2_wr_ready", bus.wr_ready, 1);
        read_row(100);
        chk("f2_old_data", bus.row_size, 100);
        write_rows(200, 479, 1000);
        chk("f2_wr_ready_drop", bus.wr_ready, 0);
        pulse_frame_end();
        chk("f2_trace_start", bus.trace_start, 1);
        chk("f2_missed_same", bus.missed_swaps, 1);
        read_row(100);
        chk("f2_r100_size", bus.row_size, 1100);
        chk("f2_r100_texu", bus.row_texu, 12);

        // Frame 3 (base 500): final write, frame_end and a read in one cycle
        write_rows(0, 478, 500);
        set_entry(979);
        bus.wr_valid  = 1'b1;
        bus.frame_end = 1'b1;
        bus.rd_en     = 1'b1;
        bus.rd_row    = 9'd10;
        step();
        bus.wr_valid  = 1'b0;
        bus.frame_end = 1'b0;
        bus.rd_en     = 1'b0;
        chk("f3_read_old_bank", bus.row_size, 1010);
        chk("f3_trace_start", bus.trace_start, 1);
        chk("f3_missed_same", bus.missed_swaps, 1);
        chk("f3_wr_ready", bus.wr_ready, 1);
        read_row(10);
        chk("f3_read_new_bank", bus.row_size, 510);
        read_row(479);
        chk("f3_r479_size", bus.row_size, 979);
        chk("f3_r479_texu", bus.row_texu, 19);
        chk("f3_r479_wall", bus.row_wall, 3);
        chk("f3_r479_side", bus.row_side, 1);

        // Frame 4 (base 1500): pointer restarted at 0 after the merged swap
        write_rows(0, 478, 1500);
        chk("f4_ready_at_478", bus.wr_ready, 1);
        write_rows(479, 479, 1500);
        chk("f4_ready_drop", bus.wr_ready, 0);
        pulse_frame_end();
        chk("f4_trace_start", bus.trace_start, 1);
        read_row(0);
        chk("f4_r0_size", bus.row_size, 1500);
        read_row(100);
        chk("f4_r100_size", bus.row_size, 1600);

        // Saturation of missed_swaps
        repeat (250) begin
            pulse_frame_end();
            step();
        end
        chk("sat_251", bus.missed_swaps, 251);
        repeat (50) begin
            pulse_frame_end();
            step();
        end
        chk("sat_255", bus.missed_swaps, 255);
        chk("sat_front_valid", bus.front_valid, 1);
        read_row(100);
        chk("sat_r100_kept", bus.row_size, 1600);

        // Async reset in the middle of a fill
        write_rows(0, 36, 2000);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_front_valid", bus.front_valid, 0);
        chk("arst_row_size", bus.row_size, 0);
        chk("arst_wr_ready", bus.wr_ready, 0);
        chk("arst_missed", bus.missed_swaps, 0);
        step();
        reset = 1'b0;
        step();
        chk("arst_restart_pulse", bus.trace_start, 1);
        chk("arst_restart_ready", bus.wr_ready, 1);
        read_row(5);
        chk("arst_read_zero", bus.row_size, 0);
        chk("arst_front_invalid", bus.front_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
